// File: rtl/instruction_fetch_unit_if.sv
// Bus bundle between the fetch unit and its PC, program memory and decode stage.
// master = fetch unit side, slave = PC/memory/decode side.
interface instruction_fetch_unit_if;
  logic       Run;
  logic [3:0] Pc_Addr;
  logic       Pc_Enable;
  logic [3:0] Pc_Incr;
  logic [3:0] Pc_Load_Value;
  logic       Mem_Req;
  logic [3:0] Mem_Addr;
  logic       Mem_Ack;
  logic [7:0] Mem_Data;
  logic       Ir_Valid;
  logic       Ir_Ready;
  logic [3:0] Ir_Opcode;
  logic [3:0] Ir_Operand;
  logic       Fetch_Err;

  modport master (
    input  Run, Pc_Addr, Mem_Ack, Mem_Data, Ir_Ready,
    output Pc_Enable, Pc_Incr, Pc_Load_Value, Mem_Req, Mem_Addr,
           Ir_Valid, Ir_Opcode, Ir_Operand, Fetch_Err
  );

  modport slave (
    output Run, Pc_Addr, Mem_Ack, Mem_Data, Ir_Ready,
    input  Pc_Enable, Pc_Incr, Pc_Load_Value, Mem_Req, Mem_Addr,
           Ir_Valid, Ir_Opcode, Ir_Operand, Fetch_Err
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch sequencer: reads program memory at the PC, latches the instruction register, steers the PC.
// Define FETCH_TIMEOUT_EN to abort a read after 15 un-acked request cycles (sticky Fetch_Err, HALT).
module instruction_fetch_unit #(
  parameter logic [3:0] Incr      = 4'd1,
  parameter logic [3:0] JmpOpcode = 4'hC,
  parameter logic [3:0] HltOpcode = 4'hF
) (
  input  logic                    Clk,
  input  logic                    Rst,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {StIdle, StReq, StPresent, StJump, StHalt} state_e;

  state_e     state_q, state_d;
  logic [3:0] mem_addr_q, mem_addr_d;
  logic [3:0] ir_opcode_q, ir_opcode_d;
  logic [3:0] ir_operand_q, ir_operand_d;
  logic [3:0] jump_target_q, jump_target_d;

  logic [3:0] ack_opcode;
  logic       ack_is_jmp;
  logic       ack_is_hlt;
  logic       timeout;

  assign ack_opcode = bus.Mem_Data[7:4];
  assign ack_is_jmp = (ack_opcode == JmpOpcode);
  assign ack_is_hlt = (ack_opcode == HltOpcode);

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 15;
  localparam int unsigned CntW          = $clog2(TimeoutCycles);

  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            fetch_err_q, fetch_err_d;

  // Fires in the last allowed un-acked REQ cycle; an ack in that cycle wins.
  assign timeout = (state_q == StReq) && !bus.Mem_Ack &&
                   (tmo_cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == StReq && !bus.Mem_Ack) tmo_cnt_d = tmo_cnt_q + CntW'(1);
    fetch_err_d = fetch_err_q | timeout;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmo_cnt_q   <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      tmo_cnt_q   <= tmo_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign bus.Fetch_Err = fetch_err_q;
`else
  assign timeout       = 1'b0;
  assign bus.Fetch_Err = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Run) state_d = StReq;
      end
      StReq: begin
        if (bus.Mem_Ack) begin
          if (ack_is_jmp)      state_d = StJump;
          else if (ack_is_hlt) state_d = StHalt;
          else                 state_d = StPresent;
        end else if (timeout) begin
          state_d = StHalt;
        end
      end
      StPresent: begin
        if (bus.Ir_Ready) state_d = bus.Run ? StReq : StIdle;
      end
      StJump:  state_d = bus.Run ? StReq : StIdle;
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: fetch address, instruction register, jump target.
  always_comb begin
    mem_addr_d    = mem_addr_q;
    ir_opcode_d   = ir_opcode_q;
    ir_operand_d  = ir_operand_q;
    jump_target_d = jump_target_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Run) mem_addr_d = bus.Pc_Addr;
      end
      StReq: begin
        if (bus.Mem_Ack) begin
          if (ack_is_jmp) begin
            jump_target_d = bus.Mem_Data[3:0];
          end else begin
            ir_opcode_d  = ack_opcode;
            ir_operand_d = bus.Mem_Data[3:0];
          end
        end
      end
      StPresent: begin
        if (bus.Ir_Ready && bus.Run) mem_addr_d = bus.Pc_Addr;
      end
      StJump: begin
        // The PC only takes the target at this edge, so Pc_Addr is still stale here.
        if (bus.Run) mem_addr_d = jump_target_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem_addr_q    <= '0;
      ir_opcode_q   <= '0;
      ir_operand_q  <= '0;
      jump_target_q <= '0;
    end else begin
      mem_addr_q    <= mem_addr_d;
      ir_opcode_q   <= ir_opcode_d;
      ir_operand_q  <= ir_operand_d;
      jump_target_q <= jump_target_d;
    end
  end

  // Outputs. The PC loads Pc_Load_Value whenever Pc_Enable is low, so hold = reload Pc_Addr.
  always_comb begin
    bus.Mem_Req       = 1'b0;
    bus.Ir_Valid      = 1'b0;
    bus.Pc_Enable     = 1'b0;
    bus.Pc_Load_Value = bus.Pc_Addr;
    unique case (state_q)
      StReq: begin
        bus.Mem_Req   = 1'b1;
        // An ack racing a reset is discarded, so it must not advance the PC either.
        bus.Pc_Enable = bus.Mem_Ack && !ack_is_jmp && !ack_is_hlt && !Rst;
      end
      StPresent: bus.Ir_Valid      = 1'b1;
      StJump:    bus.Pc_Load_Value = jump_target_q;
      default: ;
    endcase
  end

  assign bus.Pc_Incr    = Incr;
  assign bus.Mem_Addr   = mem_addr_q;
  assign bus.Ir_Opcode  = ir_opcode_q;
  assign bus.Ir_Operand = ir_operand_q;

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch sequencer sitting directly downstream of the 4-bit program counter. It takes the PC value as the fetch address, runs a req/ack read against program memory, and latches the returned byte into an instruction register split into opcode and operand. It then presents the instruction to decode with a valid/ready handshake. It also drives the PC's Enable/Incr/Load_Value inputs: increment after each fetch, load on jump, hold otherwise.

## Interface
- INCR, 4'd1, PC increment applied per non-jump fetch
- JMP_OPCODE, 4'hC, opcode handled internally as absolute jump to operand
- HLT_OPCODE, 4'hF, opcode that stops fetching
- TIMEOUT_CYCLES, 15, max REQ cycles without ack (used only with FETCH_TIMEOUT_EN)

Ports:
- Clk  in  1  clock, all state on posedge
- Rst  in  1  synchronous, active-high reset
- Run  in  1  fetch enable
- Pc_Addr  in  4  current PC value
- Pc_Enable  out  1  PC increment strobe
- Pc_Incr  out  4  constant INCR
- Pc_Load_Value  out  4  value the PC loads whenever Pc_Enable=0
- Mem_Req  out  1  read request
- Mem_Addr  out  4  registered read address
- Mem_Ack  in  1  read complete; Mem_Data valid this cycle
- Mem_Data  in  8  instruction byte, [7:4] opcode, [3:0] operand
- Ir_Valid  out  1  instruction available to decode
- Ir_Ready  in  1  decode accepts instruction
- Ir_Opcode  out  4  registered opcode
- Ir_Operand  out  4  registered operand
- Fetch_Err  out  1  sticky memory-timeout flag

## Operation
- PC loads Load_Value on every edge with Enable=0, so hold means Pc_Load_Value = Pc_Addr (combinational), except in JUMP, where it is jump_target.
- Pc_Enable = (state==REQ) & Mem_Ack & opcode not JMP/HLT. This is a combinational path from Mem_Ack and Mem_Data. Zero in all other cycles.
- States: IDLE, REQ, PRESENT, JUMP, HALT.
- IDLE: if Run, latch Mem_Addr<=Pc_Addr, go to REQ.
- REQ: Mem_Req=1. Without Mem_Ack, stay.
- REQ with Mem_Ack, normal opcode: latch Ir_Opcode/Ir_Operand, pulse Pc_Enable, go to PRESENT.
- REQ with Mem_Ack, JMP_OPCODE: latch jump_target<=operand, go to JUMP. Ir_Valid is not raised and the IR is not updated.
- REQ with Mem_Ack, HLT_OPCODE: latch IR, go to HALT. PC is not incremented.
- JUMP: one cycle; PC loads target at the exit edge. If Run, latch Mem_Addr<=jump_target (not Pc_Addr) and go to REQ; else go to IDLE.
- PRESENT: Ir_Valid=1, IR stable. On Ir_Ready: if Run, latch Mem_Addr<=Pc_Addr (already incremented) and go to REQ; else go to IDLE.
- HALT: all outputs idle, Ir_Valid=0. Exit only via Rst.
- Run deasserted in REQ does not abort the read: it completes, and the unit stops at the next IDLE decision point.
- Mem_Ack outside REQ is ignored.
- PC wrap 4'hF->4'h0 is the PC's arithmetic; no special handling here.

## Timing
- Reset values: state IDLE, Mem_Req=0, Mem_Addr=0, Ir_Valid=0, Ir_Opcode=0, Ir_Operand=0, Fetch_Err=0, jump_target=0.
- Rst mid-fetch: drops Mem_Req the next cycle; an outstanding ack is discarded.
- Mem_Req stays high through the ack cycle and is low the cycle after.
- Fetch loop with zero-wait memory (ack in the first REQ cycle) and Ir_Ready=1: IDLE->REQ->PRESENT->REQ, so one instruction per 2 cycles.
- Ack edge to Ir_Valid: 1 cycle. Pc_Addr shows the incremented value in the same cycle Ir_Valid rises.
- Jump costs 1 extra cycle: REQ->JUMP->REQ.

## Configuration
- FETCH_TIMEOUT_EN defined: a counter clears on REQ entry and counts REQ cycles with Mem_Ack=0. When the count reaches TIMEOUT_CYCLES, the unit drops Mem_Req, sets Fetch_Err (sticky until Rst) and goes to HALT. An ack arriving in the same cycle wins.
- FETCH_TIMEOUT_EN undefined: no counter, REQ waits indefinitely, Fetch_Err tied 0.

## Test plan
- Reset, Run=1, PC=3, memory[3]=8'h25 with ack next cycle -> Mem_Addr=3. Pc_Enable pulses once, then PC=4, Ir_Opcode=2, Ir_Operand=5, Ir_Valid=1.
- Ir_Ready held low 5 cycles -> Ir_Valid and IR stable, no new Mem_Req, PC stays 4. Ready high -> next Mem_Req with Mem_Addr=4.
- memory[4]=8'hC9 -> no Ir_Valid, JUMP state one cycle, PC=9, next Mem_Addr=9.
- PC=F, normal opcode -> PC wraps to 0, next fetch Mem_Addr=0.
- memory word 8'hF0 -> HALT, Pc_Enable never pulses, Mem_Req stays 0 until Rst. Rst asserted mid-REQ -> Mem_Req=0 the next cycle.
- With FETCH_TIMEOUT_EN and no ack -> Mem_Req high 15 cycles, then Fetch_Err=1 and HALT. Ack on cycle 15 -> normal fetch, Fetch_Err=0.
